// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - serial a-b-bin subtractor, one nibble per clock; optional overflow flag via SUB_OVERFLOW_EN
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_r;
  logic             borrow_r;
  logic [IDXW-1:0]  idx;

  logic [3:0]       x;
  logic [3:0]       y;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [4:0]       c;
  logic [3:0]       nib;
  logic [WIDTH+3:0] res_cat;
  logic [WIDTH-1:0] res_next;
  logic             last_nib;

  // Operands shift right so the current nibble is always the low four bits.
  // The result fills from the top, so it is aligned after N steps.
  assign last_nib = (state == RUN) && (idx == LAST);

  // Borrow-lookahead stage for the current nibble
  always_comb begin
    x        = a_sh[3:0];
    y        = b_sh[3:0];
    p        = ~(x ^ y);
    g        = ~x & y;
    c[0]     = borrow_r;
    c[1]     = g[0] | (p[0] & c[0]);
    c[2]     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
    nib      = x ^ y ^ c[3:0];
    res_cat  = {nib, res_r};
    res_next = res_cat[WIDTH+3:4];
  end

  // Control FSM, operand/result datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_r    <= '0;
      borrow_r <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            borrow_r <= bin;
            idx      <= '0;
            ready    <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> 4;
          b_sh     <= b_sh >> 4;
          borrow_r <= c[4];
          res_r    <= res_next;
          idx      <= idx + 1'b1;
          if (last_nib) begin
            // Outputs take the final result on the edge entering DONE
            diff  <= res_next;
            bout  <= c[4];
            done  <= 1'b1;
            idx   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic sign_a;
  logic sign_b;
  logic ovf_r;

  // Signed overflow: operand signs differ and the result sign differs from a
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sign_a <= a[WIDTH-1];
        sign_b <= b[WIDTH-1];
      end
      if (last_nib) begin
        ovf_r <= (sign_a != sign_b) && (nib[3] != sign_a);
      end
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule
